// File: rtl/seq_divider_su.sv
// Sequential restoring divider with per-operand signed/unsigned mode and WIDTH+1 bit results.
// Optional macro SEQ_DIVIDER_EARLY_EXIT_EN: skip iteration when |dividend| < |divisor|.
module seq_divider_su #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       sign_mode,
  output logic [WIDTH:0]   quotient,
  output logic [WIDTH:0]   remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic [2:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] qr_q, qr_d, rem_q, rem_d, dmag_q, dmag_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   quo_q, quo_d, rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  // Operand extension and magnitudes, taken from the latched operands.
  logic             sa, sb;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH-1:0] amag, bmag;
  assign sa    = mode_q[1] & a_q[WIDTH-1];
  assign sb    = mode_q[0] & b_q[WIDTH-1];
  assign a_ext = {sa, a_q};
  assign amag  = sa ? (~a_q + 1'b1) : a_q;
  assign bmag  = sb ? (~b_q + 1'b1) : b_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] sub;
  assign trial = {rem_q, qr_q[WIDTH-1]};
  assign ge    = trial >= {1'b0, dmag_q};
  assign sub   = trial[WIDTH-1:0] - dmag_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    qr_d    = qr_q;
    rem_d   = rem_q;
    dmag_d  = dmag_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          mode_d  = sign_mode;
          if (divisor != '0) dbz_d = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        negq_d = sa ^ sb;
        negr_d = sa;
        dmag_d = bmag;
        qr_d   = amag;
        rem_d  = '0;
        cnt_d  = CW'(WIDTH - 1);
        if (b_q == '0) begin
          quo_d   = '1;
          rmd_d   = a_ext;
          dbz_d   = 1'b1;
          state_d = DONE;
        end
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
        else if (amag < bmag) begin
          qr_d    = '0;
          rem_d   = amag;
          state_d = FIX;
        end
`endif
        else begin
          state_d = ITER;
        end
      end
      ITER: begin
        qr_d  = {qr_q[WIDTH-2:0], ge};
        rem_d = ge ? sub : trial[WIDTH-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        // Zero magnitudes negate to zero, so a zero remainder stays 0.
        quo_d   = negq_q ? (~{1'b0, qr_q} + 1'b1) : {1'b0, qr_q};
        rmd_d   = negr_q ? (~{1'b0, rem_q} + 1'b1) : {1'b0, rem_q};
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      qr_q    <= '0;
      rem_q   <= '0;
      dmag_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      qr_q    <= qr_d;
      rem_q   <= rem_d;
      dmag_q  <= dmag_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign done        = (state_q == DONE);
  assign busy        = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider_su.sv
// Directed bench for seq_divider_su (WIDTH=16): results, latency, busy/done timing,
// ignored starts, divide-by-zero and reset abort.
module tb_seq_divider_su;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend, divisor;
  logic [1:0]  sign_mode;
  logic [16:0] quotient, remainder;
  logic        done, busy, div_by_zero;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  seq_divider_su #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .sign_mode   (sign_mode),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] m, input int exp_lat, input logic [16:0] exp_q,
                         input logic [16:0] exp_r, input logic exp_dbz,
                         input int repulse_at, input bit poke_done);
    int edges;
    int busy_bad;
    dividend  = a;
    divisor   = b;
    sign_mode = m;
    start     = 1'b1;
    @(posedge clk);
    edges    = 1;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b0;
    while (!done && edges < 60) begin
      start = (edges == repulse_at);
      if (start) begin
        dividend = 16'd99;
        divisor  = 16'd9;
      end
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_lat"}, edges, exp_lat);
    check({tag, "_busy_run"}, busy_bad, 0);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    check({tag, "_dbz"}, div_by_zero, exp_dbz);
    if (poke_done) begin
      dividend = 16'd5;
      divisor  = 16'd1;
      start    = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_q_hold"}, quotient, exp_q);
    if (poke_done) check({tag, "_start_in_done_ignored"}, busy, 1'b0);
  endtask

  initial begin
    int edges;
    int done_seen;
    rst       = 1'b1;
    start     = 1'b1;
    dividend  = 16'd77;
    divisor   = 16'd7;
    sign_mode = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q", quotient, 17'd0);
    check("rst_r", remainder, 17'd0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    start = 1'b0;
    rst   = 1'b0;

    run_div("u100_7",   16'd100,  16'd7,    2'b00, 19, 17'd14,     17'd2,     1'b0, 0, 1'b1);
    run_div("s100_7",   16'hFF9C, 16'd7,    2'b11, 19, 17'h1FFF2,  17'h1FFFE, 1'b0, 0, 1'b0);
    run_div("ffff_m1",  16'hFFFF, 16'hFFFF, 2'b01, 19, 17'h10001,  17'd0,     1'b0, 0, 1'b0);
    run_div("min_m1",   16'h8000, 16'hFFFF, 2'b11, 19, 17'h08000,  17'd0,     1'b0, 0, 1'b0);
    run_div("dz1234",   16'd1234, 16'd0,    2'b00, 2,  17'h1FFFF,  17'd1234,  1'b1, 0, 1'b0);
    run_div("u9_3",     16'd9,    16'd3,    2'b00, 19, 17'd3,      17'd0,     1'b0, 0, 1'b0);
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    run_div("u3_10",    16'd3,    16'd10,   2'b00, 3,  17'd0,      17'd3,     1'b0, 0, 1'b0);
`else
    run_div("u3_10",    16'd3,    16'd10,   2'b00, 19, 17'd0,      17'd3,     1'b0, 0, 1'b0);
`endif
    run_div("sm7_2",    16'hFFF9, 16'd2,    2'b10, 19, 17'h1FFFD,  17'h1FFFF, 1'b0, 0, 1'b0);
    run_div("s7_m2",    16'd7,    16'hFFFE, 2'b01, 19, 17'h1FFFD,  17'd1,     1'b0, 0, 1'b0);
    run_div("uffff_1",  16'hFFFF, 16'd1,    2'b00, 19, 17'h0FFFF,  17'd0,     1'b0, 0, 1'b0);
    run_div("dzmin",    16'h8000, 16'd0,    2'b10, 2,  17'h1FFFF,  17'h18000, 1'b1, 0, 1'b0);
    run_div("repulse",  16'd50,   16'd5,    2'b00, 19, 17'd10,     17'd0,     1'b0, 5, 1'b0);

    // Reset in the middle of a division: outputs clear and no done follows.
    dividend  = 16'd1000;
    divisor   = 16'd3;
    sign_mode = 2'b00;
    start     = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    while (edges < 8) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_q", quotient, 17'd0);
    check("abort_r", remainder, 17'd0);
    check("abort_dbz", div_by_zero, 1'b0);
    check("abort_state", dbg_state, 3'd0);
    done_seen = 0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
